lsu: RTL and testbench
======================

LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter TIMEOUT, default 255: bus-wait cycles before a forced error completion (range 1..255).
REQ-002 Port clk  in  1: single clock; all state changes on its rising edge.
REQ-003 Port rst  in  1: reset, synchronous, active-high.
REQ-004 Port inst_i  in  32: instruction from ex; funct3 = inst_i[14:12].
REQ-005 Port reg_w_ena_i / reg_w_addr_i / reg_w_data_i  in  1/5/32: ex writeback request and ALU result.
REQ-006 Port ram_r_ena_i / ram_r_addr_i  in  1/32: load request and byte address.
REQ-007 Port ram_w_ena_i / ram_w_addr_i / ram_w_data_i  in  1/32/32: store request, byte address, rs2 data.
REQ-008 Port bus_req_o / bus_we_o / bus_addr_o / bus_be_o / bus_wdata_o  out  1/1/32/4/32: data-bus request.
REQ-009 Port bus_ack_i / bus_rdata_i  in  1/32: bus completion and read data, valid when bus_ack_i=1.
REQ-010 Port stall_o  out  1: to ctrl; upstream stages hold while 1.
REQ-011 Port reg_w_ena_o / reg_w_addr_o / reg_w_data_o  out  1/5/32: registered writeback to wb.
REQ-012 Port err_o / misalign_o  out  1/1: one-cycle pulses for timeout and misaligned access.

Function
REQ-013 FSM states: IDLE, WAIT; a memory op is ram_r_ena_i or ram_w_ena_i while in IDLE; both asserted together: store takes priority.
REQ-014 IDLE, no memory op: next cycle reg_w_*_o = reg_w_*_i (1-cycle latency), stall_o=0.
REQ-015 IDLE, memory op: stall_o=1 combinationally; latch op; next cycle enter WAIT with bus_req_o=1; reg_w_ena_o=0 that cycle.
REQ-016 bus_addr_o = {addr[31:2],2'b00}; bus_we_o=1 for stores; bus_* held stable throughout WAIT.
REQ-017 Store lanes: SB wdata={4{d[7:0]}}, be=4'b0001<<addr[1:0]; SH wdata={2{d[15:0]}}, be=addr[1]?4'b1100:4'b0011; SW be=4'b1111.
REQ-018 Load extract: LB/LBU byte at addr[1:0], LH/LHU halfword at addr[1], LW full word; LB/LH sign-extend, LBU/LHU zero-extend; other funct3: LW.
REQ-019 WAIT, bus_ack_i=0: stall_o=1, timeout counter +1.
REQ-020 WAIT, bus_ack_i=1: stall_o=0 same cycle; next cycle bus_req_o=0, IDLE, load result on reg_w_data_o with reg_w_ena_o=latched reg_w_ena_i; stores give reg_w_ena_o=0.
REQ-021 Timeout (counter reaches TIMEOUT without ack): as REQ-020 but data 0, reg_w_ena_o=0, err_o=1 for one cycle; late ack ignored.
REQ-022 Timeout counter cleared on every entry to WAIT; 8 bits, never wraps.

Reset
REQ-023 rst=1 at an edge: state IDLE, counter 0, all outputs 0 next cycle, including mid-WAIT (bus transaction abandoned, no err_o).

Configuration
REQ-024 Macro LSU_MISALIGN_CHK_EN defined: halfword with addr[0]=1 or word with addr[1:0]!=0 is not issued to the bus; completes in 1 cycle, reg_w_ena_o=0, misalign_o=1 for one cycle, stall_o=0.
REQ-025 Macro undefined: misalign_o tied 0; misaligned offsets ignored (halfword uses addr[1], word ignores addr[1:0]).

Structure
REQ-026 Shared defines header holds INST/REG/REGADDR/MEMADDR widths and load/store funct3 codes.
REQ-027 Combinational sub-module lsu_align: byte-enable, store-lane replication, load extraction/extension; lsu holds FSM, counter, output registers.

Verification
REQ-028 ALU op reg_w_ena_i=1, addr 5, data 0x1234 -> next cycle reg_w_addr_o=5, reg_w_data_o=0x1234, no bus_req_o.
REQ-029 LB addr 0x103, ack after 3 cycles, rdata 0x80FFFFFF -> bus_addr_o=0x100, stall_o=1 for 4 cycles, reg_w_data_o=0xFFFFFF80.
REQ-030 SH addr 0x202, data 0xABCD -> bus_be_o=4'b1100, bus_wdata_o=0xABCDABCD, bus_we_o=1, reg_w_ena_o=0.
REQ-031 LW, ack never arrives, TIMEOUT=4 -> err_o pulse once, reg_w_ena_o=0, IDLE, stall_o released.
REQ-032 rst=1 in 2nd WAIT cycle -> next cycle bus_req_o=0, stall_o=0, all outputs 0.
REQ-033 With LSU_MISALIGN_CHK_EN, LW addr 0x101 -> no bus_req_o, misalign_o=1 one cycle later; without it -> bus_addr_o=0x100, normal load.

Source files
------------

// File: rtl/lsu_pkg.sv
// ============================================================================
// lsu_pkg -- shared widths, funct3 codes, FSM state type and the alignment
// predicate used by the load/store unit.
//
// Contents:
//   INST_W / REG_W / REGADDR_W / MEMADDR_W : datapath widths
//   F3_*                                   : RV32I load/store funct3 codes
//   lsu_state_e                            : IDLE / WAIT
//   is_misaligned()                        : natural-alignment check per size
// ============================================================================
package lsu_pkg;

    localparam int INST_W    = 32;
    localparam int REG_W     = 32;
    localparam int REGADDR_W = 5;
    localparam int MEMADDR_W = 32;

    // Load funct3 codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // Store funct3 codes
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } lsu_state_e;

    // Halfwords need an even address, words a 4-byte aligned one; unknown
    // funct3 codes are treated as word accesses.
    function automatic logic is_misaligned(input logic       is_store,
                                           input logic [2:0] funct3,
                                           input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        if (is_store) begin
            case (funct3)
                F3_SB:   mis = 1'b0;
                F3_SH:   mis = off[0];
                default: mis = (off != 2'b00);
            endcase
        end else begin
            case (funct3)
                F3_LB, F3_LBU: mis = 1'b0;
                F3_LH, F3_LHU: mis = off[0];
                default:       mis = (off != 2'b00);
            endcase
        end
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// ============================================================================
// lsu_align -- purely combinational lane logic for the LSU.
//
// Ports:
//   st_funct3 / st_off / st_data : store size, byte offset, rs2 value
//   st_be / st_wdata             : byte enables and lane-replicated write data
//   ld_funct3 / ld_off / ld_rdata: load size, byte offset, raw bus word
//   ld_data                      : extracted and sign/zero-extended result
// ============================================================================
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]       st_funct3,
    input  logic [1:0]       st_off,
    input  logic [REG_W-1:0] st_data,
    output logic [3:0]       st_be,
    output logic [REG_W-1:0] st_wdata,
    input  logic [2:0]       ld_funct3,
    input  logic [1:0]       ld_off,
    input  logic [REG_W-1:0] ld_rdata,
    output logic [REG_W-1:0] ld_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Store lane replication and byte enables; the bus picks lanes via st_be
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = st_data;
        case (st_funct3)
            F3_SB: begin
                st_wdata = {4{st_data[7:0]}};
                st_be    = 4'b0001 << st_off;
            end
            F3_SH: begin
                st_wdata = {2{st_data[15:0]}};
                st_be    = st_off[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                st_wdata = st_data;
                st_be    = 4'b1111;
            end
        endcase
    end

    // Load lane select and extension; halfword lane follows addr[1] only
    always_comb begin
        byte_s = 8'h00;
        case (ld_off)
            2'b00:   byte_s = ld_rdata[7:0];
            2'b01:   byte_s = ld_rdata[15:8];
            2'b10:   byte_s = ld_rdata[23:16];
            2'b11:   byte_s = ld_rdata[31:24];
            default: byte_s = ld_rdata[7:0];
        endcase
        half_s = ld_off[1] ? ld_rdata[31:16] : ld_rdata[15:0];
        case (ld_funct3)
            F3_LB:   ld_data = {{24{byte_s[7]}}, byte_s};
            F3_LBU:  ld_data = {24'h000000, byte_s};
            F3_LH:   ld_data = {{16{half_s[15]}}, half_s};
            F3_LHU:  ld_data = {16'h0000, half_s};
            default: ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// ============================================================================
// lsu -- load/store unit between ex and wb with a single-outstanding data bus.
//
// Optional feature: define LSU_MISALIGN_CHK_EN to reject misaligned halfword
// and word accesses without touching the bus (misalign_o pulse). Undefined,
// misalign_o stays 0 and the low offset bits are simply ignored.
//
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   inst_i                         : instruction from ex (funct3 = [14:12])
//   reg_w_ena_i/addr_i/data_i      : writeback request and ALU result from ex
//   ram_r_ena_i/ram_r_addr_i       : load request
//   ram_w_ena_i/addr_i/data_i      : store request (store wins if both set)
//   bus_req_o/we_o/addr_o/be_o/wdata_o : data-bus request, held while waiting
//   bus_ack_i/bus_rdata_i          : bus completion and read data
//   stall_o                        : hold upstream stages (combinational)
//   reg_w_ena_o/addr_o/data_o      : registered writeback to wb
//   err_o/misalign_o               : one-cycle timeout / misalignment pulses
// ============================================================================
module lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [INST_W-1:0]    inst_i,
    input  logic                 reg_w_ena_i,
    input  logic [REGADDR_W-1:0] reg_w_addr_i,
    input  logic [REG_W-1:0]     reg_w_data_i,
    input  logic                 ram_r_ena_i,
    input  logic [MEMADDR_W-1:0] ram_r_addr_i,
    input  logic                 ram_w_ena_i,
    input  logic [MEMADDR_W-1:0] ram_w_addr_i,
    input  logic [REG_W-1:0]     ram_w_data_i,
    output logic                 bus_req_o,
    output logic                 bus_we_o,
    output logic [MEMADDR_W-1:0] bus_addr_o,
    output logic [3:0]           bus_be_o,
    output logic [REG_W-1:0]     bus_wdata_o,
    input  logic                 bus_ack_i,
    input  logic [REG_W-1:0]     bus_rdata_i,
    output logic                 stall_o,
    output logic                 reg_w_ena_o,
    output logic [REGADDR_W-1:0] reg_w_addr_o,
    output logic [REG_W-1:0]     reg_w_data_o,
    output logic                 err_o,
    output logic                 misalign_o
);

    // Timeout fires on the no-ack WAIT cycle that brings the count to TIMEOUT
    localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);

    lsu_state_e           state_r;
    logic [7:0]           cnt_r;
    logic                 lat_store_r;
    logic [2:0]           lat_f3_r;
    logic [1:0]           lat_off_r;
    logic [REGADDR_W-1:0] lat_rd_addr_r;
    logic                 lat_rd_ena_r;

    logic                 mem_op_s;
    logic [MEMADDR_W-1:0] op_addr_s;
    logic [2:0]           op_f3_s;
    logic                 misalign_s;
    logic                 timeout_s;
    logic [3:0]           al_be_s;
    logic [REG_W-1:0]     al_wdata_s;
    logic [REG_W-1:0]     al_ld_data_s;
    logic                 unused_inst_s;

    assign mem_op_s      = ram_w_ena_i | ram_r_ena_i;
    assign op_addr_s     = ram_w_ena_i ? ram_w_addr_i : ram_r_addr_i;
    assign op_f3_s       = inst_i[14:12];
    assign unused_inst_s = ^{inst_i[31:15], inst_i[11:0]};

    lsu_align u_align (
        .st_funct3 (op_f3_s),
        .st_off    (op_addr_s[1:0]),
        .st_data   (ram_w_data_i),
        .st_be     (al_be_s),
        .st_wdata  (al_wdata_s),
        .ld_funct3 (lat_f3_r),
        .ld_off    (lat_off_r),
        .ld_rdata  (bus_rdata_i),
        .ld_data   (al_ld_data_s)
    );

    // Misaligned-access detection for the op presented in IDLE
    always_comb begin
`ifdef LSU_MISALIGN_CHK_EN
        misalign_s = mem_op_s & is_misaligned(ram_w_ena_i, op_f3_s, op_addr_s[1:0]);
`else
        misalign_s = 1'b0;
`endif
    end

    // Bus-wait timeout condition; an ack in the same cycle takes precedence
    always_comb begin
        if ((state_r == ST_WAIT) && !bus_ack_i && (cnt_r == TIMEOUT_M1)) begin
            timeout_s = 1'b1;
        end else begin
            timeout_s = 1'b0;
        end
    end

    // Stall: raised as soon as a bus op is seen, dropped in the completing cycle
    always_comb begin
        stall_o = 1'b0;
        case (state_r)
            ST_IDLE: stall_o = mem_op_s & ~misalign_s;
            ST_WAIT: stall_o = ~bus_ack_i & ~timeout_s;
            default: stall_o = 1'b0;
        endcase
    end

    // FSM, timeout counter, latched op fields and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            cnt_r         <= 8'd0;
            lat_store_r   <= 1'b0;
            lat_f3_r      <= 3'd0;
            lat_off_r     <= 2'd0;
            lat_rd_addr_r <= 5'd0;
            lat_rd_ena_r  <= 1'b0;
            bus_req_o     <= 1'b0;
            bus_we_o      <= 1'b0;
            bus_addr_o    <= 32'd0;
            bus_be_o      <= 4'd0;
            bus_wdata_o   <= 32'd0;
            reg_w_ena_o   <= 1'b0;
            reg_w_addr_o  <= 5'd0;
            reg_w_data_o  <= 32'd0;
            err_o         <= 1'b0;
            misalign_o    <= 1'b0;
        end else begin
            err_o      <= 1'b0;
            misalign_o <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (mem_op_s && misalign_s) begin
                        reg_w_ena_o  <= 1'b0;
                        reg_w_addr_o <= 5'd0;
                        reg_w_data_o <= 32'd0;
                        misalign_o   <= 1'b1;
                    end else if (mem_op_s) begin
                        state_r       <= ST_WAIT;
                        cnt_r         <= 8'd0;
                        lat_store_r   <= ram_w_ena_i;
                        lat_f3_r      <= op_f3_s;
                        lat_off_r     <= op_addr_s[1:0];
                        lat_rd_addr_r <= reg_w_addr_i;
                        lat_rd_ena_r  <= reg_w_ena_i;
                        bus_req_o     <= 1'b1;
                        bus_we_o      <= ram_w_ena_i;
                        bus_addr_o    <= {op_addr_s[31:2], 2'b00};
                        bus_be_o      <= ram_w_ena_i ? al_be_s : 4'b1111;
                        bus_wdata_o   <= ram_w_ena_i ? al_wdata_s : 32'd0;
                        reg_w_ena_o   <= 1'b0;
                        reg_w_addr_o  <= 5'd0;
                        reg_w_data_o  <= 32'd0;
                    end else begin
                        reg_w_ena_o  <= reg_w_ena_i;
                        reg_w_addr_o <= reg_w_addr_i;
                        reg_w_data_o <= reg_w_data_i;
                    end
                end
                ST_WAIT: begin
                    if (bus_ack_i || timeout_s) begin
                        state_r      <= ST_IDLE;
                        bus_req_o    <= 1'b0;
                        bus_we_o     <= 1'b0;
                        bus_addr_o   <= 32'd0;
                        bus_be_o     <= 4'd0;
                        bus_wdata_o  <= 32'd0;
                        reg_w_addr_o <= lat_rd_addr_r;
                        if (bus_ack_i && !lat_store_r) begin
                            reg_w_ena_o  <= lat_rd_ena_r;
                            reg_w_data_o <= al_ld_data_s;
                        end else begin
                            reg_w_ena_o  <= 1'b0;
                            reg_w_data_o <= 32'd0;
                        end
                        err_o <= timeout_s;
                    end else begin
                        cnt_r       <= (cnt_r == 8'hFF) ? 8'hFF : cnt_r + 8'd1;
                        reg_w_ena_o <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    bus_req_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// ============================================================================
// tb_lsu -- randomized scoreboard bench for lsu (TIMEOUT = 4).
// A driver issues one operation at a time, holds it while stall_o is high,
// plays the bus slave, and pushes the expected writeback and bus request
// into queues. A monitor pops and compares on the cycle after acceptance.
// ============================================================================
module tb_lsu;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst_i;
    logic        reg_w_ena_i;
    logic [4:0]  reg_w_addr_i;
    logic [31:0] reg_w_data_i;
    logic        ram_r_ena_i;
    logic [31:0] ram_r_addr_i;
    logic        ram_w_ena_i;
    logic [31:0] ram_w_addr_i;
    logic [31:0] ram_w_data_i;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;
    logic        stall_o;
    logic        reg_w_ena_o;
    logic [4:0]  reg_w_addr_o;
    logic [31:0] reg_w_data_o;
    logic        err_o;
    logic        misalign_o;

    lsu #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .inst_i(inst_i),
        .reg_w_ena_i(reg_w_ena_i), .reg_w_addr_i(reg_w_addr_i), .reg_w_data_i(reg_w_data_i),
        .ram_r_ena_i(ram_r_ena_i), .ram_r_addr_i(ram_r_addr_i),
        .ram_w_ena_i(ram_w_ena_i), .ram_w_addr_i(ram_w_addr_i), .ram_w_data_i(ram_w_data_i),
        .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
        .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i), .stall_o(stall_o),
        .reg_w_ena_o(reg_w_ena_o), .reg_w_addr_o(reg_w_addr_o), .reg_w_data_o(reg_w_data_o),
        .err_o(err_o), .misalign_o(misalign_o)
    );

    // Free-running clock
    always #5 clk = ~clk;

    typedef struct {
        bit        ena;
        bit [4:0]  addr;
        bit [31:0] data;
        bit        chk_addr;
        bit        chk_data;
        bit        err;
        bit        mis;
        int        stall;
    } res_t;

    typedef struct {
        bit        we;
        bit [31:0] addr;
        bit [3:0]  be;
        bit [31:0] wdata;
        bit        chk_lanes;
    } bus_t;

    res_t res_q[$];
    bus_t bus_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    bit   mon_en    = 1'b0;
    bit   late_ack  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h want 0x%08h at t=%0t", name, act, exp, $time);
    endtask

    // Access size in bytes from the opcode rules (store wins when both set)
    function automatic int size_of(input bit st, input bit [2:0] f3);
        if (st) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        if (f3 == 3'd0 || f3 == 3'd4) return 1;
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        return 4;
    endfunction

    // Issue one op (called at posedge+1), hold it until accepted, act as bus slave
    task automatic run_op(input bit ld, input bit st, input bit [2:0] f3,
                          input bit [31:0] addr, input bit [31:0] wdata,
                          input bit rena, input bit [4:0] rad, input bit [31:0] rdat,
                          input bit [31:0] brdata, input int lat, input bit noack);
        res_t r;
        bus_t b;
        int size, off, hoff, cyc, wcnt;
        bit mis, done;
        bit [31:0] v, inst;
        size = size_of(st, f3);
        off  = int'(addr % 32'd4);
        hoff = (off >= 2) ? 2 : 0;
`ifdef LSU_MISALIGN_CHK_EN
        mis = (ld || st) && ((size == 2 && (off % 2) != 0) || (size == 4 && off != 0));
`else
        mis = 1'b0;
`endif
        r = '{ena: rena, addr: rad, data: rdat, chk_addr: 1'b1, chk_data: 1'b1,
              err: 1'b0, mis: 1'b0, stall: 0};
        if ((ld || st) && mis) begin
            r = '{ena: 1'b0, addr: 5'd0, data: 32'd0, chk_addr: 1'b0, chk_data: 1'b0,
                  err: 1'b0, mis: 1'b1, stall: 0};
        end else if (ld || st) begin
            b.we = st;
            b.addr = addr & 32'hFFFF_FFFC;
            b.chk_lanes = st;
            if (size == 1) begin
                b.be = 4'(1 << off);
                b.wdata = (wdata & 32'hFF) * 32'h0101_0101;
            end else if (size == 2) begin
                b.be = 4'(3 << hoff);
                b.wdata = (wdata & 32'hFFFF) * 32'h0001_0001;
            end else begin
                b.be = 4'hF;
                b.wdata = wdata;
            end
            bus_q.push_back(b);
            if (noack) begin
                r = '{ena: 1'b0, addr: 5'd0, data: 32'd0, chk_addr: 1'b0, chk_data: 1'b1,
                      err: 1'b1, mis: 1'b0, stall: TO};
            end else if (st) begin
                r = '{ena: 1'b0, addr: 5'd0, data: 32'd0, chk_addr: 1'b0, chk_data: 1'b0,
                      err: 1'b0, mis: 1'b0, stall: lat + 1};
            end else begin
                if (size == 1) begin
                    v = (brdata >> (8 * off)) & 32'hFF;
                    if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
                end else if (size == 2) begin
                    v = (brdata >> (8 * hoff)) & 32'hFFFF;
                    if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
                end else begin
                    v = brdata;
                end
                r = '{ena: rena, addr: rad, data: v, chk_addr: rena, chk_data: rena,
                      err: 1'b0, mis: 1'b0, stall: lat + 1};
            end
        end
        res_q.push_back(r);

        inst = $urandom;
        inst[14:12] = f3;
        inst_i       = inst;
        reg_w_ena_i  = rena;
        reg_w_addr_i = rad;
        reg_w_data_i = rdat;
        ram_r_ena_i  = ld;
        ram_w_ena_i  = st;
        ram_r_addr_i = (ld && !st) ? addr : $urandom;
        ram_w_addr_i = st ? addr : $urandom;
        ram_w_data_i = wdata;
        mon_en = 1'b1;

        wcnt = 0;
        done = 1'b0;
        cyc  = 0;
        while (!done && cyc < 300) begin
            @(negedge clk);
            if (bus_req_o) begin
                if (!noack && wcnt == lat) begin
                    bus_ack_i = 1'b1;
                    bus_rdata_i = brdata;
                end else begin
                    bus_ack_i = 1'b0;
                    bus_rdata_i = $urandom;
                end
                wcnt++;
            end else begin
                bus_ack_i = late_ack;
                bus_rdata_i = $urandom;
                late_ack = 1'b0;
            end
            #1;
            done = !stall_o;
            @(posedge clk);
            #1;
            bus_ack_i = 1'b0;
            cyc++;
        end
        if (!done) begin
            $display("FAIL op_accept_budget: got stall after %0d cycles want release", cyc);
            total_cnt++;
            $display("%0d/%0d checks passed", pass_cnt, total_cnt);
            $fatal(1, "op never accepted");
        end
        late_ack = noack;
    endtask

    // Scoreboard monitor: result the cycle after acceptance, bus request on rise
    bit   chk_prev  = 1'b0;
    bit   bus_prev  = 1'b0;
    int   stall_cnt = 0;
    int   acc_stall = 0;
    bus_t cur_bus;
    res_t r_m;
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (chk_prev) begin
                if (res_q.size() == 0) begin
                    chk("res_queue_underflow", 32'd1, 32'd0);
                end else begin
                    r_m = res_q.pop_front();
                    chk("stall_cycles", acc_stall, r_m.stall);
                    chk("reg_w_ena_o", reg_w_ena_o, r_m.ena);
                    if (r_m.chk_addr) chk("reg_w_addr_o", reg_w_addr_o, r_m.addr);
                    if (r_m.chk_data) chk("reg_w_data_o", reg_w_data_o, r_m.data);
                    chk("err_o", err_o, r_m.err);
                    chk("misalign_o", misalign_o, r_m.mis);
                    chk("bus_req_released", bus_req_o, 32'd0);
                end
            end else if (mon_en) begin
                chk("quiet_ena_err_mis", {reg_w_ena_o, err_o, misalign_o}, 32'd0);
            end
            if (mon_en) begin
                if (bus_req_o && !bus_prev) begin
                    if (bus_q.size() == 0) begin
                        chk("bus_unexpected", 32'd1, 32'd0);
                    end else begin
                        cur_bus = bus_q.pop_front();
                        chk("bus_addr_o", bus_addr_o, cur_bus.addr);
                        chk("bus_we_o", bus_we_o, cur_bus.we);
                        if (cur_bus.chk_lanes) begin
                            chk("bus_be_o", bus_be_o, cur_bus.be);
                            chk("bus_wdata_o", bus_wdata_o, cur_bus.wdata);
                        end
                    end
                end else if (bus_req_o) begin
                    chk("bus_held_addr", {bus_we_o, bus_addr_o[31:1]}, {cur_bus.we, cur_bus.addr[31:1]});
                    if (cur_bus.chk_lanes) chk("bus_held_wdata", bus_wdata_o, cur_bus.wdata);
                end
                if (stall_o) stall_cnt++;
            end
            chk_prev = mon_en && !stall_o && !rst;
            if (chk_prev) begin
                acc_stall = stall_cnt;
                stall_cnt = 0;
            end
            if (!mon_en) stall_cnt = 0;
            bus_prev = bus_req_o;
        end
    end

    int        wc;
    bit [2:0]  ld_f3_tbl [8] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
    initial begin
        rst = 1'b1;
        inst_i = 32'd0; reg_w_ena_i = 1'b0; reg_w_addr_i = 5'd0; reg_w_data_i = 32'd0;
        ram_r_ena_i = 1'b0; ram_r_addr_i = 32'd0; ram_w_ena_i = 1'b0;
        ram_w_addr_i = 32'd0; ram_w_data_i = 32'd0; bus_ack_i = 1'b0; bus_rdata_i = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_bus_req", bus_req_o, 32'd0);
        chk("rst_stall", stall_o, 32'd0);
        chk("rst_reg_w", {reg_w_ena_o, reg_w_addr_o}, 32'd0);
        chk("rst_reg_data", reg_w_data_o, 32'd0);
        chk("rst_pulses", {err_o, misalign_o, bus_we_o, bus_be_o}, 32'd0);
        chk("rst_bus_addr", bus_addr_o, 32'd0);
        chk("rst_bus_wdata", bus_wdata_o, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Directed cases
        run_op(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 5'd5, 32'h1234, 32'd0, 0, 1'b0);
        run_op(1'b1, 1'b0, 3'd0, 32'h103, 32'd0, 1'b1, 5'd7, 32'd0, 32'h80FF_FFFF, 3, 1'b0);
        run_op(1'b0, 1'b1, 3'd1, 32'h202, 32'h0000_ABCD, 1'b1, 5'd9, 32'd0, 32'd0, 1, 1'b0);
        run_op(1'b1, 1'b0, 3'd2, 32'h300, 32'd0, 1'b1, 5'd3, 32'd0, 32'h5555_AAAA, 0, 1'b1);
        run_op(1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 1'b1, 5'd4, 32'hCAFE_F00D, 32'd0, 0, 1'b0);
        run_op(1'b1, 1'b0, 3'd2, 32'h101, 32'd0, 1'b1, 5'd11, 32'd0, 32'h1122_3344, 0, 1'b0);
        run_op(1'b1, 1'b1, 3'd0, 32'h407, 32'h0000_005A, 1'b1, 5'd12, 32'd0, 32'd0, 2, 1'b0);
        run_op(1'b1, 1'b0, 3'd5, 32'h502, 32'd0, 1'b1, 5'd13, 32'd0, 32'h9ABC_1234, 1, 1'b0);

        // Randomized mix
        for (int i = 0; i < 80; i++) begin
            int kind;
            bit noack;
            kind  = $urandom_range(0, 9);
            noack = ($urandom_range(0, 15) == 0);
            if (kind <= 3)
                run_op(1'b0, 1'b0, 3'($urandom), 32'd0, 32'd0, 1'($urandom), 5'($urandom),
                       $urandom, 32'd0, 0, 1'b0);
            else if (kind <= 6)
                run_op(1'b1, 1'b0, ld_f3_tbl[$urandom_range(0, 7)], $urandom, 32'd0, 1'($urandom),
                       5'($urandom), $urandom, $urandom, $urandom_range(0, TO - 1), noack);
            else
                run_op(kind == 9, 1'b1, 3'($urandom_range(0, 2)), $urandom, $urandom, 1'($urandom),
                       5'($urandom), $urandom, $urandom, $urandom_range(0, TO - 1), noack);
        end

        reg_w_ena_i = 1'b0; ram_r_ena_i = 1'b0; ram_w_ena_i = 1'b0;
        mon_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("res_queue_drained", res_q.size(), 32'd0);
        chk("bus_queue_drained", bus_q.size(), 32'd0);

        // Reset in the second WAIT cycle of a load that is never acked
        @(posedge clk);
        #1;
        inst_i = 32'h0000_2000; ram_r_ena_i = 1'b1; ram_r_addr_i = 32'h40;
        reg_w_ena_i = 1'b1; reg_w_addr_i = 5'd6;
        wc = 0;
        for (int k = 0; k < 20 && wc < 2; k++) begin
            @(negedge clk);
            if (bus_req_o) wc++;
        end
        chk("rst_test_wait_seen", wc, 32'd2);
        rst = 1'b1;
        ram_r_ena_i = 1'b0; reg_w_ena_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midwait_rst_bus_req", bus_req_o, 32'd0);
        chk("midwait_rst_stall", stall_o, 32'd0);
        chk("midwait_rst_outs", {reg_w_ena_o, err_o, misalign_o, bus_we_o}, 32'd0);
        chk("midwait_rst_data", reg_w_data_o, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("midwait_rst_no_err", {err_o, bus_req_o}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
